uart_tx_fifo_feeder: RTL and testbench

Byte FIFO with a launch state machine that sits directly upstream of the UART transmitter. It accepts bytes from a producer (CPU/bus logic) at full clock rate and buffers them. It feeds them one at a time to the transmitter's DV/Byte inputs, then waits for the transmitter's done pulse before launching the next byte. An optional inter-byte idle gap is supported.

---
 rtl/uart_tx_fifo_feeder_if.sv | 28 ++
 rtl/uart_tx_fifo_feeder.sv | 123 ++++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_feeder_if.sv
// Producer-side and transmitter-side handshake bundle for the UART TX FIFO feeder.
// The count width follows DEPTH, so it must match the feeder instance it connects to.
interface uart_tx_fifo_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_Wr_DV;
    logic [7:0]    i_Wr_Byte;
    logic          o_Full;
    logic          o_Empty;
    logic [CW-1:0] o_Count;
    logic          o_Overflow;
    logic          o_TX_DV;
    logic [7:0]    o_TX_Byte;
    logic          i_TX_Active;
    logic          i_TX_Done;

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
    );

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter one byte per done pulse,
// with an optional idle gap between completion and the next launch.
module uart_tx_fifo_feeder #(
    parameter int DEPTH    = 16,
    parameter int GAP_CLKS = 0
) (
    input logic                   i_Clock,
    input logic                   i_Rst_L,
    uart_tx_fifo_feeder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic [GW-1:0] gap_cnt_r;
    logic [GW-1:0] gap_cnt_s;
    logic          wr_ok_s;
    logic          launch_s;
    logic          tx_dv_r;
    logic [7:0]    tx_byte_r;
    logic          overflow_r;
    logic          full_r;
    logic          empty_r;

    assign bus.o_TX_DV    = tx_dv_r;
    assign bus.o_TX_Byte  = tx_byte_r;
    assign bus.o_Overflow = overflow_r;
    assign bus.o_Count    = count_r;
    assign bus.o_Full     = full_r;
    assign bus.o_Empty    = empty_r;

    // Launch FSM next state plus FIFO write/pop decisions (fullness uses pre-edge count).
    always_comb begin
        state_s   = state_r;
        gap_cnt_s = gap_cnt_r;
        launch_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if ((count_r != {CW{1'b0}}) && !bus.i_TX_Active) begin
                    launch_s = 1'b1;
                    state_s  = WAIT_DONE;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (bus.i_TX_Done) begin
                    if (GAP_CLKS == 0) begin
                        state_s = IDLE;
                    end else begin
                        gap_cnt_s = {GW{1'b0}};
                        state_s   = GAP;
                    end
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            GAP: begin
                gap_cnt_s = gap_cnt_r + GW'(1'b1);
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s   = IDLE;
                gap_cnt_s = {GW{1'b0}};
            end
        endcase
        wr_ok_s = bus.i_Wr_DV && (count_r != FULL_CNT);
        count_s = count_r + CW'(wr_ok_s) - CW'(launch_s);
    end

    // Control, pointer, count and registered output state.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r    <= IDLE;
            gap_cnt_r  <= {GW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            tx_dv_r    <= 1'b0;
            tx_byte_r  <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            gap_cnt_r  <= gap_cnt_s;
            wr_ptr_r   <= wr_ptr_r + AW'(wr_ok_s);
            rd_ptr_r   <= rd_ptr_r + AW'(launch_s);
            count_r    <= count_s;
            full_r     <= (count_s == FULL_CNT);
            empty_r    <= (count_s == {CW{1'b0}});
            tx_dv_r    <= launch_s;
            tx_byte_r  <= launch_s ? mem_r[rd_ptr_r] : tx_byte_r;
            overflow_r <= bus.i_Wr_DV && (count_r == FULL_CNT);
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge i_Clock) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= bus.i_Wr_Byte;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench: DUT a (DEPTH=4, no gap) covers most behaviour; DUT b (DEPTH=16, GAP_CLKS=5) covers the gap.
module tb_uart_tx_fifo_feeder;
    localparam int TX_CLKS = 40;   // CLKS_PER_BIT=4, 10 bit times per frame

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    uart_tx_fifo_feeder_if #(.DEPTH(4))  a ();
    uart_tx_fifo_feeder_if #(.DEPTH(16)) b ();

    uart_tx_fifo_feeder #(.DEPTH(4),  .GAP_CLKS(0)) dut_a (.i_Clock(clk), .i_Rst_L(rst_n), .bus(a));
    uart_tx_fifo_feeder #(.DEPTH(16), .GAP_CLKS(5)) dut_b (.i_Clock(clk), .i_Rst_L(rst_n), .bus(b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter models: busy TX_CLKS cycles per launch, then a one-cycle done pulse.
    logic a_act, a_done, a_hold, b_act, b_done;
    int   a_cnt, b_cnt;
    assign a.i_TX_Active = a_act | a_hold;
    assign a.i_TX_Done   = a_done;
    assign b.i_TX_Active = b_act;
    assign b.i_TX_Done   = b_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_act <= 1'b0; a_done <= 1'b0; a_cnt <= 0;
        end else begin
            a_done <= 1'b0;
            if (a.o_TX_DV && !a_act) begin
                a_act <= 1'b1; a_cnt <= TX_CLKS;
            end else if (a_act) begin
                if (a_cnt == 1) begin a_act <= 1'b0; a_done <= 1'b1; end
                else a_cnt <= a_cnt - 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_act <= 1'b0; b_done <= 1'b0; b_cnt <= 0;
        end else begin
            b_done <= 1'b0;
            if (b.o_TX_DV && !b_act) begin
                b_act <= 1'b1; b_cnt <= TX_CLKS;
            end else if (b_act) begin
                if (b_cnt == 1) begin b_act <= 1'b0; b_done <= 1'b1; end
                else b_cnt <= b_cnt - 1;
            end
        end
    end

    // Launch/done monitor: records the edge index after which each event is visible.
    logic [7:0] a_q[$], b_q[$];
    int a_dv_c[$], a_dn_c[$], b_dv_c[$], b_dn_c[$];
    always @(posedge clk) begin
        #1;
        if (a.o_TX_DV) begin a_q.push_back(a.o_TX_Byte); a_dv_c.push_back(cyc); end
        if (a.i_TX_Done) a_dn_c.push_back(cyc);
        if (b.o_TX_DV) begin b_q.push_back(b.o_TX_Byte); b_dv_c.push_back(cyc); end
        if (b.i_TX_Done) b_dn_c.push_back(cyc);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic clear_q();
        a_q.delete(); a_dv_c.delete(); a_dn_c.delete();
        b_q.delete(); b_dv_c.delete(); b_dn_c.delete();
    endtask

    task automatic a_write(input logic [7:0] d);
        a.i_Wr_DV = 1'b1; a.i_Wr_Byte = d;
        @(negedge clk);
        a.i_Wr_DV = 1'b0;
    endtask

    task automatic wait_dv(input bit sel_b, input int n, input int budget);
        int k = 0;
        while (((sel_b ? b_q.size() : a_q.size()) < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check(sel_b ? "b_dv_count" : "a_dv_count", sel_b ? b_q.size() : a_q.size(), n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_dv"},   a.o_TX_DV,    1'b0);
        check({tag, "_tx_byte"}, a.o_TX_Byte,  8'h00);
        check({tag, "_count"},   a.o_Count,    3'd0);
        check({tag, "_empty"},   a.o_Empty,    1'b1);
        check({tag, "_full"},    a.o_Full,     1'b0);
        check({tag, "_ovf"},     a.o_Overflow, 1'b0);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;
    vec_t vt[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        vt[0] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 8'h10, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 8'h12, 3'd3, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 8'h13, 3'd4, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 8'h14, 3'd4, 1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b1, 8'h15, 3'd4, 1'b1, 1'b0, 1'b1};
        vt[7] = '{1'b0, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0};

        a.i_Wr_DV = 1'b0; a.i_Wr_Byte = 8'h00; a_hold = 1'b1;
        b.i_Wr_DV = 1'b0; b.i_Wr_Byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Full/overflow with transmitter held busy.
        for (int i = 0; i < 8; i++) begin
            a.i_Wr_DV = vt[i].wr; a.i_Wr_Byte = vt[i].d;
            @(negedge clk);
            check($sformatf("ovf_vec%0d_count", i), a.o_Count,    vt[i].cnt);
            check($sformatf("ovf_vec%0d_full", i),  a.o_Full,     vt[i].full);
            check($sformatf("ovf_vec%0d_empty", i), a.o_Empty,    vt[i].empty);
            check($sformatf("ovf_vec%0d_ovf", i),   a.o_Overflow, vt[i].ovf);
        end
        check("ovf_no_dv_while_active", a_q.size(), 0);
        a_hold = 1'b0;
        wait_dv(1'b0, 4, 400);
        repeat (60) @(negedge clk);
        check("ovf_drain_count", a_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("ovf_byte%0d", i), a_q[i], 8'h10 + i);
        check("ovf_drain_empty", a.o_Empty, 1'b1);

        // Single byte latency and one-cycle DV.
        clear_q();
        t0 = cyc;
        a_write(8'hA5);
        check("single_count_1", a.o_Count, 3'd1);
        @(negedge clk);
        check("single_dv_high", a.o_TX_DV, 1'b1);
        check("single_byte", a.o_TX_Byte, 8'hA5);
        check("single_count_0", a.o_Count, 3'd0);
        @(negedge clk);
        check("single_dv_low", a.o_TX_DV, 1'b0);
        repeat (80) @(negedge clk);
        check("single_one_dv", a_q.size(), 1);
        check("single_dv_edge", a_dv_c[0], t0 + 2);

        // Burst of four: order and done-to-DV spacing.
        clear_q();
        for (int i = 1; i <= 4; i++) a_write(8'(i));
        wait_dv(1'b0, 4, 400);
        repeat (60) @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("burst_byte%0d", i), a_q[i], 8'h01 + i);
        for (int i = 0; i < 3; i++) check($sformatf("burst_gap%0d", i), a_dv_c[i+1] - a_dn_c[i], 2);
        check("burst_empty", a.o_Empty, 1'b1);

        // Wrap: keep three stored, write exactly on each launch edge.
        clear_q();
        a_hold = 1'b1;
        for (int i = 0; i < 4; i++) a_write(8'h20 + 8'(i));
        a_hold = 1'b0;
        for (int i = 0; i < 12; i++) begin
            k = 0;
            while (!a.i_TX_Done && k < 200) begin @(negedge clk); k++; end
            check($sformatf("wrap_done%0d", i), (k < 200), 1'b1);
            @(negedge clk);
            a_write(8'h24 + 8'(i));
            check($sformatf("wrap_count%0d", i), a.o_Count, 3'd3);
        end
        wait_dv(1'b0, 16, 600);
        repeat (60) @(negedge clk);
        for (int i = 0; i < 16; i++) check($sformatf("wrap_byte%0d", i), a_q[i], 8'h20 + i);

        // Inter-byte gap on the GAP_CLKS=5 instance.
        clear_q();
        b.i_Wr_DV = 1'b1; b.i_Wr_Byte = 8'h5A; @(negedge clk);
        b.i_Wr_Byte = 8'hC3; @(negedge clk);
        b.i_Wr_DV = 1'b0;
        wait_dv(1'b1, 2, 300);
        check("gap_byte0", b_q[0], 8'h5A);
        check("gap_byte1", b_q[1], 8'hC3);
        check("gap_spacing", b_dv_c[1] - b_dn_c[0], 7);

        // Asynchronous reset mid-transfer.
        repeat (60) @(negedge clk);
        clear_q();
        for (int i = 0; i < 4; i++) a_write(8'h77 + 8'(i));
        repeat (10) @(negedge clk);
        check("rst_pre_count", a.o_Count, 3'd3);
        check("rst_pre_byte", a.o_TX_Byte, 8'h77);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("midrst_no_dv", a_q.size(), 1);
        check("midrst_count", a.o_Count, 3'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
